mont_mul: RTL and testbench

MONT_MUL -- requirements
Module: mont_mul

---
 rtl/mont_mul_if.sv | 22 ++
 rtl/mont_mul.sv | 110 +++++++++++
 tb/tb_mont_mul.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mont_mul_if.sv
// Montgomery multiplier request/response bundle.
interface mont_mul_if #(
    parameter int WIDTH = 4096
);
    logic             go;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;

    modport master (
        output go, a, b, n,
        input  result, busy, done
    );

    modport slave (
        input  go, a, b, n,
        output result, busy, done
    );
endinterface

// File: rtl/mont_mul.sv
// Radix-2 bit-serial Montgomery multiplier: result = a*b*2^-WIDTH mod n.
// Fixed latency of WIDTH+1 cycles from accepted start to done.
module mont_mul #(
    parameter int WIDTH = 4096
) (
    input  logic     clk,
    input  logic     rst_n,
    mont_mul_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FINAL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH+1:0] s_q, s_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH+1:0] sum_ab;
    logic [WIDTH+1:0] sum_abn;
    logic [WIDTH-1:0] s_minus_n;
    logic             last_iter;

    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // One Montgomery step on the current multiplier bit plus the final-subtract candidate.
    always_comb begin
        sum_ab    = s_q + (a_q[0] ? {2'b00, b_q} : '0);
        sum_abn   = sum_ab + (sum_ab[0] ? {2'b00, n_q} : '0);
        // S < 2n, so S-n fits in WIDTH bits whenever it is selected.
        s_minus_n = s_q[WIDTH-1:0] - n_q;
    end

    // Next-state, operand capture and output generation.
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        a_d      = a_q;
        b_d      = b_q;
        n_d      = n_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.go) begin
                    state_d = RUN;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    n_d     = bus.n;
                    s_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                s_d   = sum_abn >> 1;
                a_d   = a_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                result_d = (s_q >= {2'b00, n_q}) ? s_minus_n : s_q[WIDTH-1:0];
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            a_q      <= a_d;
            b_q      <= b_d;
            n_q      <= n_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_mont_mul.sv
// Self-checking bench for mont_mul: WIDTH=8 vector table with a result
// scoreboard, multi-cycle corner sequences, and one WIDTH=4096 run.
module tb_mont_mul;
    localparam int W  = 8;
    localparam int WB = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mont_mul_if #(.WIDTH(W))  bus ();
    mont_mul_if #(.WIDTH(WB)) bbus ();

    mont_mul #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    mont_mul #(.WIDTH(WB)) dut_big (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bbus.slave)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] n;
        logic [W-1:0] e;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    int passed   = 0;
    int total    = 0;
    int done_cnt = 0;
    logic [W-1:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Reference: reduce a*b mod n, then divide by 2 mod n, W times.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] n);
        logic [2*W+1:0] x;
        logic [2*W+1:0] aa;
        aa = {{(W+2){1'b0}}, a};
        x  = (aa * b) % n;
        for (int unsigned i = 0; i < W; i++) begin
            if (x[0]) x = x + n;
            x = x >> 1;
        end
        return x[W-1:0];
    endfunction

    // Scoreboard: every done pulse consumes one expected result.
    always @(negedge clk) begin
        if (bus.done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: got result %0d, expected no done", bus.result);
            end else begin
                check("result", 64'(bus.result), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] n, input logic [W-1:0] e, input string tag);
        int lat;
        int bc;
        bus.a  = a;
        bus.b  = b;
        bus.n  = n;
        bus.go = 1'b1;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        bus.go = 1'b0;
        // Operands must be latched; disturb the inputs for the rest of the run.
        bus.a = ~a;
        bus.b = ~b;
        bus.n = n ^ 8'h5A;
        check({tag, "_busy_start"}, 64'(bus.busy), 64'd1);
        check({tag, "_done_low"}, 64'(bus.done), 64'd0);
        lat = 0;
        bc  = 0;
        while (!bus.done && lat < 50) begin
            if (bus.busy) bc++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(W + 1));
        check({tag, "_busy_cycles"}, 64'(bc), 64'(W + 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        int lat;
        logic [WB-1:0] nb;
        logic [WB:0]   x;
        logic [WB-1:0] r_big;
        logic [WB-1:0] t_big;

        bus.go  = 1'b0;
        bus.a   = '0;
        bus.b   = '0;
        bus.n   = '0;
        bbus.go = 1'b0;
        bbus.a  = '0;
        bbus.b  = '0;
        bbus.n  = '0;

        vecs[0] = '{a: 8'd5,   b: 8'd7,   n: 8'd13,  e: 8'd1};
        vecs[1] = '{a: 8'd254, b: 8'd254, n: 8'd255, e: 8'd1};
        vecs[2] = '{a: 8'd0,   b: 8'd12,  n: 8'd13,  e: 8'd0};
        vecs[3] = '{a: 8'd9,   b: 8'd9,   n: 8'd13,  e: 8'd9};
        vecs[4] = '{a: 8'd12,  b: 8'd12,  n: 8'd13,  e: 8'd3};
        vecs[5] = '{a: 8'd1,   b: 8'd1,   n: 8'd255, e: 8'd1};
        vecs[6] = '{a: 8'd200, b: 8'd100, n: 8'd251, e: 8'd235};
        vecs[7] = '{a: 8'd8,   b: 8'd8,   n: 8'd9,   e: 8'd7};
        for (int i = 8; i < NVEC; i++) begin
            logic [W-1:0] nn;
            nn = 8'($urandom_range(3, 255)) | 8'd1;
            vecs[i].n = nn;
            vecs[i].a = 8'($urandom_range(0, int'(nn) - 1));
            vecs[i].b = 8'($urandom_range(0, int'(nn) - 1));
            vecs[i].e = model(vecs[i].a, vecs[i].b, nn);
        end

        #1;
        check("reset_result", 64'(bus.result), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table, applied back-to-back (each start in the cycle after done).
        for (int i = 0; i < NVEC; i++) begin
            run_one(vecs[i].a, vecs[i].b, vecs[i].n, vecs[i].e, $sformatf("vec%0d", i));
        end

        // go held during RUN and FINAL with changing operands: ignored.
        repeat (3) @(posedge clk);
        #1;
        dc = done_cnt;
        bus.a  = 8'd5;
        bus.b  = 8'd7;
        bus.n  = 8'd13;
        bus.go = 1'b1;
        @(posedge clk);
        exp_q.push_back(8'd1);
        #1;
        for (int i = 0; i < W + 1; i++) begin
            bus.a  = 8'($urandom);
            bus.b  = 8'($urandom);
            bus.n  = 8'($urandom);
            bus.go = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.go = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("busy_go_done_count", 64'(done_cnt - dc), 64'd1);
        check("result_held", 64'(bus.result), 64'd1);

        // Reset at iteration 3 aborts with no done.
        bus.a  = 8'd5;
        bus.b  = 8'd7;
        bus.n  = 8'd13;
        bus.go = 1'b1;
        @(posedge clk);
        exp_q.push_back(8'd1);
        #1;
        bus.go = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_result", 64'(bus.result), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        exp_q.delete();
        dc = done_cnt;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt - dc), 64'd0);
        run_one(8'd5, 8'd7, 8'd13, 8'd1, "post_reset");
        @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        // Full width: a = t = 2^(2*WB) mod n, b = 1 gives r = 2^WB mod n.
        for (int i = 0; i < WB / 32; i++) nb[i*32 +: 32] = $urandom;
        nb[0]      = 1'b1;
        nb[WB-1]   = 1'b1;
        x = {{WB{1'b0}}, 1'b1};
        for (int i = 0; i < 2 * WB; i++) begin
            x = x << 1;
            if (x >= {1'b0, nb}) x = x - {1'b0, nb};
            if (i == WB - 1) r_big = x[WB-1:0];
        end
        t_big = x[WB-1:0];
        bbus.a  = t_big;
        bbus.b  = {{(WB-1){1'b0}}, 1'b1};
        bbus.n  = nb;
        bbus.go = 1'b1;
        @(posedge clk);
        #1;
        bbus.go = 1'b0;
        lat = 0;
        while (!bbus.done && lat < 5000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("big_latency", 64'(lat), 64'(WB + 1));
        total++;
        if (bbus.result === r_big) passed++;
        else $display("FAIL big_result: got low64 %h, expected low64 %h",
                      bbus.result[63:0], r_big[63:0]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
